// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: writeback request bus (valid/addr/data/one-hot ready) between result sources and the arbiter
interface rf_writeback_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*5-1:0]    req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin share of the RF write port plus pending-write scoreboard; RF_WB_BYPASS_EN adds rs forwarding
module rf_writeback_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rf_writeback_arbiter_if.slave req,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic                  issue_stall,
  output logic                  rs_stall,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
`ifdef RF_WB_BYPASS_EN
  ,
  output logic                  rs1_fwd_en,
  output logic                  rs2_fwd_en,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data
`endif
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]   rr_ptr, win;
  logic            found;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;
  logic [31:0]     pend;
  logic            set_en, hit1, hit2, fwd1, fwd2;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    req.req_ready = found ? NUM_REQ'(1) << win : '0;
  end
  assign win_addr = req.req_addr[int'(win)*5 +: 5];
  assign win_data = req.req_data[int'(win)*XLEN +: XLEN];
  assign issue_stall = pend[issue_rd];
  assign set_en = issue_valid && !issue_stall && issue_rd != 5'd0;
  assign hit1 = rs1_addr != 5'd0 && pend[rs1_addr];
  assign hit2 = rs2_addr != 5'd0 && pend[rs2_addr];
`ifdef RF_WB_BYPASS_EN
  assign fwd1 = rf_we && rs1_addr != 5'd0 && rf_waddr == rs1_addr;
  assign fwd2 = rf_we && rs2_addr != 5'd0 && rf_waddr == rs2_addr;
  assign rs1_fwd_en   = fwd1;
  assign rs2_fwd_en   = fwd2;
  assign rs1_fwd_data = fwd1 ? rf_wdata : '0;
  assign rs2_fwd_data = fwd2 ? rf_wdata : '0;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign rs_stall = (hit1 && !fwd1) || (hit2 && !fwd2);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
      pend     <= '0;
    end else begin
      rf_we <= found && win_addr != 5'd0;
      if (found) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        rr_ptr   <= int'(win) == NUM_REQ - 1 ? '0 : win + PW'(1);
      end
      pend <= (pend & ~(rf_we ? 32'd1 << rf_waddr : 32'd0) | (set_en ? 32'd1 << issue_rd : 32'd0)) & ~32'd1;
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed and random checks of the writeback arbiter against a behavioural model
module tb_rf_writeback_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;
  logic clk = 1'b0, reset_n = 1'b0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic issue_stall, rs_stall, rf_we;
  logic [4:0] rf_waddr;
  logic [XL-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
  logic rs1_fwd_en, rs2_fwd_en;
  logic [XL-1:0] rs1_fwd_data, rs2_fwd_data;
`endif
  rf_writeback_arbiter_if #(.NUM_REQ(N), .XLEN(XL)) bus ();
  rf_writeback_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .reset_n(reset_n), .req(bus),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .issue_stall(issue_stall), .rs_stall(rs_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_WB_BYPASS_EN
    , .rs1_fwd_en(rs1_fwd_en), .rs2_fwd_en(rs2_fwd_en),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[5*i +: 5] = a;
    bus.req_data[XL*i +: XL] = d;
  endtask
  int m_ptr;
  bit m_pend[32];
  bit m_we, m_init = 1'b0;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  always @(negedge clk) begin : model
    int w;
    bit st, b1, b2, f1, f2;
    logic [N-1:0] g;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && bus.req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    if (m_init) begin
      chk("ready", bus.req_ready, g);
      chk("rf_we", rf_we, m_we);
      if (m_we) begin
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
      end
      chk("issue_stall", issue_stall, m_pend[issue_rd]);
      b1 = rs1_addr != 0 && m_pend[rs1_addr];
      b2 = rs2_addr != 0 && m_pend[rs2_addr];
      f1 = 1'b0;
      f2 = 1'b0;
`ifdef RF_WB_BYPASS_EN
      f1 = m_we && rs1_addr != 0 && m_waddr == rs1_addr;
      f2 = m_we && rs2_addr != 0 && m_waddr == rs2_addr;
      chk("rs1_fwd_en", rs1_fwd_en, f1);
      chk("rs2_fwd_en", rs2_fwd_en, f2);
      if (f1) chk("rs1_fwd_data", rs1_fwd_data, m_wdata);
      if (f2) chk("rs2_fwd_data", rs2_fwd_data, m_wdata);
`endif
      chk("rs_stall", rs_stall, (b1 && !f1) || (b2 && !f2));
    end
    if (!reset_n) begin
      m_init = 1'b1;
      m_ptr = 0;
      m_we = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else if (m_init) begin
      st = m_pend[issue_rd];
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (issue_valid && !st && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_we = 1'b0;
      if (w >= 0) begin
        m_waddr = bus.req_addr[5*w +: 5];
        m_wdata = bus.req_data[XL*w +: XL];
        m_we = m_waddr != 0;
        m_ptr = (w + 1) % N;
      end
    end
  end
  initial begin
    logic [N-1:0] gexp [6];
    logic [4:0] aexp [3];
    gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    aexp = '{5'd1, 5'd2, 5'd3};
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) put(i, aexp[i], 32'hA000_0000 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_ready", bus.req_ready, 3'b001);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", bus.req_ready, gexp[i]);
      if (i > 0) begin
        chk("rr_we", rf_we, 1'b1);
        chk("rr_waddr", rf_waddr, aexp[(i-1)%3]);
      end
      step();
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rr_last_waddr", rf_waddr, 5'd3);
    chk("rr_last_wdata", rf_wdata, 32'hA000_0002);
    step();
    put(0, 5'd0, 32'hDEADBEEF);
    @(negedge clk);
    chk("x0_ready", bus.req_ready, 3'b001);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("x0_we", rf_we, 1'b0);
    step();
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    @(negedge clk);
    chk("raw_issue_ok", issue_stall, 1'b0);
    step();
    issue_valid = 1'b0;
    rs1_addr = 5'd5;
    @(negedge clk);
    chk("raw_stall", rs_stall, 1'b1);
    step();
    put(1, 5'd5, 32'h1234);
    @(negedge clk);
    chk("raw_ready", bus.req_ready, 3'b010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("raw_we", rf_we, 1'b1);
`ifdef RF_WB_BYPASS_EN
    chk("raw_bypass_stall", rs_stall, 1'b0);
    chk("raw_fwd_en", rs1_fwd_en, 1'b1);
    chk("raw_fwd_data", rs1_fwd_data, 32'h1234);
`else
    chk("raw_hold_stall", rs_stall, 1'b1);
`endif
    step();
    @(negedge clk);
    chk("raw_clear", rs_stall, 1'b0);
    step();
    rs1_addr = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    @(negedge clk);
    chk("waw_first", issue_stall, 1'b0);
    step();
    @(negedge clk);
    chk("waw_stall", issue_stall, 1'b1);
    step();
    issue_valid = 1'b0;
    put(2, 5'd7, 32'h77);
    @(negedge clk);
    chk("waw_ready", bus.req_ready, 3'b100);
    chk("waw_still", issue_stall, 1'b1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("waw_we", rf_we, 1'b1);
    chk("waw_waddr", rf_waddr, 5'd7);
    chk("waw_during_write", issue_stall, 1'b1);
    step();
    issue_valid = 1'b1;
    @(negedge clk);
    chk("waw_accept", issue_stall, 1'b0);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("waw_repend", issue_stall, 1'b1);
    step();
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    @(negedge clk);
    step();
    issue_rd = 5'd12;
    @(negedge clk);
    step();
    issue_valid = 1'b0;
    put(0, 5'd9, 32'h99);
    rs1_addr = 5'd9;
    rs2_addr = 5'd12;
    @(negedge clk);
    chk("mid_ready", bus.req_ready, 3'b001);
    chk("mid_stall", rs_stall, 1'b1);
    step();
    bus.req_valid = '0;
    reset_n = 1'b0;
    @(negedge clk);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_we", rf_we, 1'b0);
    chk("mid_rs_clear", rs_stall, 1'b0);
    chk("mid_issue_clear", issue_stall, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      step();
      reset_n = $urandom_range(0, 299) != 0;
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_addr[5*i +: 5] = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 15));
        bus.req_data[XL*i +: XL] = $urandom;
      end
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 15));
      rs1_addr = 5'($urandom_range(0, 15));
      rs2_addr = 5'($urandom_range(0, 15));
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
